// File: rtl/design_18_mlane_pipe.sv
// design_18_mlane_pipe: multi-lane arithmetic pipeline with valid/ready handshake.
// Each accepted transaction applies one 2-bit mode to LANES independent W-bit
// operand pairs. The result is computed at stage 1 and then shifts through
// STAGES register stages. The tail stage drives the outputs straight from
// registers.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   mode                00 wrap add, 01 wrap sub, 10 saturating add, 11 max
//   a, b                lane i operand at bits [i*W +: W]
//   out_valid/out_ready output handshake
//   y, ovf              per-lane result and flag taken from the tail stage
//   done_cnt            count of output handshakes, wraps
module design_18_mlane_pipe #(
  parameter int unsigned W      = 16,
  parameter int unsigned LANES  = 2,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic [LANES*W-1:0]   a,
  input  logic [LANES*W-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   y,
  output logic [LANES-1:0]     ovf,
  output logic [CNT_W-1:0]     done_cnt
);

  localparam int unsigned DW = LANES * W;

  logic [STAGES-1:0] vld_q;
  logic [DW-1:0]     y_q   [STAGES];
  logic [LANES-1:0]  ovf_q [STAGES];
  logic [CNT_W-1:0]  cnt_q;

  logic [DW-1:0]     y_d;
  logic [LANES-1:0]  ovf_d;
  logic [W-1:0]      op_a;
  logic [W-1:0]      op_b;
  logic [W:0]        sum;
  logic [W:0]        dif;
  logic              adv;

  // The whole pipe moves together unless the tail holds data the consumer refuses.
  assign out_valid = vld_q[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign y         = y_q[STAGES-1];
  assign ovf       = ovf_q[STAGES-1];
  assign done_cnt  = cnt_q;

  // Stage-1 lane arithmetic. The extra top bit of sum/dif is the carry or borrow.
  always_comb begin
    y_d   = '0;
    ovf_d = '0;
    op_a  = '0;
    op_b  = '0;
    sum   = '0;
    dif   = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      op_a = a[l*W +: W];
      op_b = b[l*W +: W];
      sum  = {1'b0, op_a} + {1'b0, op_b};
      dif  = {1'b0, op_a} - {1'b0, op_b};
      case (mode)
        2'b00: begin
          y_d[l*W +: W] = sum[W-1:0];
          ovf_d[l]      = sum[W];
        end
        2'b01: begin
          y_d[l*W +: W] = dif[W-1:0];
          ovf_d[l]      = dif[W];
        end
        2'b10: begin
          y_d[l*W +: W] = sum[W] ? {W{1'b1}} : sum[W-1:0];
          ovf_d[l]      = sum[W];
        end
        default: begin
          y_d[l*W +: W] = (op_a >= op_b) ? op_a : op_b;
          ovf_d[l]      = (op_a == op_b);
        end
      endcase
    end
  end

  // Stage registers and the completion counter. A bubble enters when in_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        y_q[s]   <= '0;
        ovf_q[s] <= '0;
      end
    end else begin
      if (adv) begin
        vld_q[0] <= in_valid;
        y_q[0]   <= y_d;
        ovf_q[0] <= ovf_d;
        for (int unsigned s = 1; s < STAGES; s++) begin
          vld_q[s] <= vld_q[s-1];
          y_q[s]   <= y_q[s-1];
          ovf_q[s] <= ovf_q[s-1];
        end
      end
      if (out_valid && out_ready) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/design_18_mlane_pipe.md
Name: design_18_mlane_pipe

Overview:
- Parametrised successor of the two-operand registered arithmetic unit with start/valid control.
- Processes LANES independent operand pairs per transaction through a STAGES-deep pipeline.
- Each transaction carries its own operation mode. A valid/ready handshake on both sides gives full backpressure.
- Sits between the operand source and the result consumer in the datapath. Exposes per-lane overflow flags and a completed-transaction counter.

Parameters:
- W, 16, operand/result width per lane (>=2)
- LANES, 2, number of parallel lanes (>=1)
- STAGES, 2, pipeline depth in register stages (1..8)
- CNT_W, 16, width of completed-transaction counter

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  transaction offered
- in_ready  output  1  transaction accepted when in_valid & in_ready
- mode  input  2  00 wrap add, 01 wrap sub (a-b), 10 unsigned saturating add, 11 unsigned max
- a  input  LANES*W  lane i operand at bits [i*W +: W]
- b  input  LANES*W  lane i operand, same packing
- out_valid  output  1  result present at pipeline tail
- out_ready  input  1  consumer accepts when out_valid & out_ready
- y  output  LANES*W  lane results, same packing as a
- ovf  output  LANES  per-lane flag (see Behaviour)
- done_cnt  output  CNT_W  completed output handshakes, wraps modulo 2^CNT_W

Behaviour:
- Reset, evaluated at the clock edge while rst=1:
  - All stage valid bits, y, ovf and done_cnt go to 0. in_ready reads 1 in the first cycle after reset releases.
  - Reset mid-operation discards all in-flight transactions. No output handshake occurs in the reset cycle.
- Pipeline:
  - Stage s holds {valid_s, mode_s, y_s, ovf_s}.
  - Stage 1 is loaded with the combinational result of a, b and mode on input acceptance.
  - Stages 2..STAGES shift the value forward. The tail stage drives out_valid, y and ovf directly from registers, with no combinational path from a/b to y.
- Advance rule:
  - adv = !out_valid | out_ready. When adv=1, all stages shift simultaneously.
  - in_ready = adv, which is combinational from out_ready and registered out_valid only.
  - When adv=0, every stage holds its value.
  - When adv=1 and in_valid=0, a bubble (valid=0) enters stage 1.
- Latency: an accepted transaction appears at out_valid exactly STAGES cycles after acceptance when out_ready is held at 1. Sustained throughput is 1 per cycle.
- Data stability: while out_valid=1 and out_ready=0, y, ovf and out_valid hold stable.
- Per-lane arithmetic, W-bit unsigned; ovf is computed in stage 1 and delayed with the data:
  - 00: y=(a+b) mod 2^W; ovf=carry out.
  - 01: y=(a-b) mod 2^W; ovf=borrow (a<b).
  - 10: y=min(a+b, 2^W-1); ovf=1 when saturation occurred.
  - 11: y=max(a,b); ovf=1 when a==b.
  - All lanes of one transaction use the same mode.
- done_cnt increments by 1 on each cycle with out_valid & out_ready. It wraps from 2^CNT_W-1 to 0.
- Simultaneous events: input acceptance and output handshake in the same cycle are both honoured, with no lost or duplicated transactions.
- Data-path content of stages with valid=0 is don't-care. y and ovf are only meaningful when out_valid=1.
- STAGES=1 is legal: a single register, with in_ready = !out_valid | out_ready.

Test Plan (W=16, LANES=2, STAGES=2, CNT_W=16):
- Reset, then mode=00, a={16'h0003,16'hFFFF}, b={16'h0004,16'h0002}, out_ready=1 -> 2 cycles later out_valid=1, y={16'h0007,16'h0001}, ovf=2'b01, done_cnt=1.
- Modes 01/10/11 with lane0 a=16'h0005,b=16'h0009 -> sub y=16'hFFFC ovf=1; sat-add y=16'h000E ovf=0; max y=16'h0009 ovf=0. Lane1 a=b=16'hFFFF -> sat-add y=16'hFFFF ovf=1; max ovf=1.
- Back-to-back 10 transactions with out_ready=1 -> 10 consecutive out_valid cycles in order, in_ready constantly 1, done_cnt=10.
- Backpressure: 3 transactions issued, out_ready=0 for 5 cycles -> in_ready drops once the tail is full, y holds stable, no loss; on release, results exit in order.
- rst=1 asserted for one cycle while 2 transactions are in flight -> next cycle out_valid=0, done_cnt=0, in_ready=1; earlier transactions never emerge.
- Counter wrap: force 65536 handshakes (or use CNT_W=4 with 16) -> done_cnt returns to 0.
